switch_bounce_gen: RTL and testbench
====================================

Name: switch_bounce_gen

Overview:
Emulates a mechanical push-button for on-board and simulation testing of the switch-debouncing path.
- On each request it drives a target level onto o_sw with a pseudo-random burst of contact bounce.
- It then holds that level clean for a settle interval and signals completion.
- It sits upstream of the debouncer input and replaces the physical switch in self-test builds.

Parameters:
N_BOUNCE, 3, number of bounce pairs after the first edge; each pair is an away-toggle plus a back-toggle; 0 allowed.
GAP_W, 8, width of the random component of the inter-toggle gap.
GAP_MIN, 4, minimum inter-toggle gap in clocks; legal range is 1 or more.
SETTLE_CYC, 1000, clocks of clean level after the final toggle before done; legal range is 1 or more.
LFSR_SEED, 16'hACE1, initial LFSR value; a value of 0 is replaced by 16'h0001.

Ports:
i_clk  in  1  system clock, single clock domain.
i_rst_n  in  1  asynchronous active-low reset.
i_req  in  1  start a switch transition; sampled only in IDLE.
i_level  in  1  target switch level; captured in the cycle i_req is accepted.
o_busy  out  1  high from the cycle after acceptance until the cycle after o_done.
o_done  out  1  one-cycle pulse when the transition is complete.
o_sw  out  1  emulated switch contact output.
o_toggles  out  8  number of o_sw edges in the current or most recent transition, including the first edge.

Behaviour:
- Reset (async assert, sync deassert by design):
  - State IDLE; o_sw=0; o_busy=0; o_done=0; o_toggles=0.
  - LFSR loads the seed; gap and settle counters are cleared.
- LFSR:
  - 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1.
  - Advances every clock, including IDLE; it is never all-zero.
- State machine states: IDLE, BOUNCE, SETTLE, DONE.
- IDLE:
  - i_req=1 in cycle k latches tgt=i_level and sets o_busy=1 at k+1.
  - If tgt==o_sw: no edge; next state is SETTLE; o_toggles is cleared to 0.
  - Otherwise: o_sw=tgt at k+1 (first edge); o_toggles=1.
    - If N_BOUNCE>0: next state is BOUNCE with remaining-toggle count 2*N_BOUNCE.
    - If N_BOUNCE=0: next state is SETTLE.
- BOUNCE:
  - On entry and after each toggle, the gap counter loads G = GAP_MIN + LFSR[GAP_W-1:0], using the LFSR value in the toggle cycle.
  - The next toggle of o_sw occurs exactly G clocks after the previous one. Each toggle increments o_toggles (saturating at 255) and decrements the remaining count.
  - When the remaining count reaches 0, o_sw==tgt by construction; next state is SETTLE.
- SETTLE:
  - The counter loads SETTLE_CYC; o_sw is held constant.
  - The transition to DONE occurs SETTLE_CYC clocks after the final edge, or after acceptance if there was no edge.
- DONE:
  - o_done=1 for exactly one cycle, then IDLE; o_busy drops in the following cycle.
- Latency, no-bounce case (N_BOUNCE=0, tgt differs): req at k, o_sw edge at k+1, o_done at k+1+SETTLE_CYC.
- Requests while o_busy=1 are ignored, not queued; i_level changes while busy have no effect.
- Requests in the DONE cycle are ignored. A request on the first IDLE cycle is accepted.
- o_sw is registered and glitch-free: at most one transition per clock.
- Mid-operation reset aborts immediately to the reset values; o_sw returns to 0 even if a transition was pending.
- Gap arithmetic uses width max(GAP_W,$clog2(GAP_MIN))+1, so there is no wrap. The maximum gap is GAP_MIN + 2^GAP_W - 1.

Test Plan:
- Reset/idle: hold i_rst_n=0 for 5 clocks, release, idle 20 clocks -> o_sw=0, o_busy=0, o_done=0, o_toggles=0 throughout.
- Clean press: N_BOUNCE=0, SETTLE_CYC=10; i_req=1, i_level=1 at cycle 100 -> o_sw rises at 101; o_done pulses only at 111; o_toggles=1; o_busy high 101..112.
- Bounced press: N_BOUNCE=2, GAP_W=2, GAP_MIN=3, SETTLE_CYC=10; req with level 1 -> exactly 5 o_sw edges, each gap in 3..6 clocks; final o_sw=1; o_toggles=5; o_done 10 clocks after the 5th edge. A reference-model LFSR predicts each gap exactly.
- Same-level request: o_sw=1, req with level 1 -> no o_sw edge; o_toggles=0; o_done 10 clocks after acceptance.
- Busy/overlap: during BOUNCE, pulse i_req with i_level=0, and also in the DONE cycle -> both ignored; a single o_done; o_sw ends at 1.
- Reset mid-bounce: assert i_rst_n=0 two clocks after the 2nd edge -> o_sw=0 and o_busy=0 asynchronously. After release, a new press completes normally with 5 edges.

Source files
------------

// File: rtl/switch_bounce_gen.sv
// rtl/switch_bounce_gen.sv - emulated push-button with pseudo-random contact bounce
module switch_bounce_gen #(
  parameter int          N_BOUNCE   = 3,
  parameter int          GAP_W      = 8,
  parameter int          GAP_MIN    = 4,
  parameter int          SETTLE_CYC = 1000,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_req,
  input  logic       i_level,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_sw,
  output logic [7:0] o_toggles
);

  // Gap width is wide enough for GAP_MIN + 2^GAP_W - 1 without wrapping.
  localparam int GW = ((GAP_W > $clog2(GAP_MIN)) ? GAP_W : $clog2(GAP_MIN)) + 1;
  localparam int SW = $clog2(SETTLE_CYC + 1);
  localparam int RW = $clog2(2 * N_BOUNCE + 1) + 1;
  localparam logic [15:0] SEED = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

  typedef enum logic [1:0] {IDLE, BOUNCE, SETTLE, DONE} state_t;

  state_t          state, state_next;
  logic            tgt, tgt_next;
  logic            sw_next, busy_next, done_next;
  logic [7:0]      tog_next;
  logic [15:0]     lfsr, lfsr_next;
  logic [GW-1:0]   gap_cnt, gap_next, gap_load;
  logic [SW-1:0]   settle_cnt, settle_next;
  logic [RW-1:0]   remain, remain_next;

  // Galois LFSR step for x^16+x^14+x^13+x^11+1; the seed is never zero so neither is the state.
  assign lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  assign gap_load  = GW'(GAP_MIN) + GW'(lfsr[GAP_W-1:0]);

  // State and datapath registers; reset forces the contact open immediately.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      tgt        <= 1'b0;
      o_sw       <= 1'b0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_toggles  <= 8'd0;
      lfsr       <= SEED;
      gap_cnt    <= '0;
      settle_cnt <= '0;
      remain     <= '0;
    end else begin
      state      <= state_next;
      tgt        <= tgt_next;
      o_sw       <= sw_next;
      o_busy     <= busy_next;
      o_done     <= done_next;
      o_toggles  <= tog_next;
      lfsr       <= lfsr_next;
      gap_cnt    <= gap_next;
      settle_cnt <= settle_next;
      remain     <= remain_next;
    end
  end

  // Next-state and next-output logic for the press sequence.
  always_comb begin
    state_next  = state;
    tgt_next    = tgt;
    sw_next     = o_sw;
    busy_next   = 1'b1;
    tog_next    = o_toggles;
    gap_next    = gap_cnt;
    settle_next = settle_cnt;
    remain_next = remain;
    case (state)
      IDLE: begin
        busy_next = 1'b0;
        if (i_req) begin
          busy_next = 1'b1;
          tgt_next  = i_level;
          if (i_level == o_sw) begin
            tog_next    = 8'd0;
            state_next  = SETTLE;
            settle_next = SW'(SETTLE_CYC);
          end else begin
            sw_next  = i_level;
            tog_next = 8'd1;
            if (N_BOUNCE > 0) begin
              state_next  = BOUNCE;
              remain_next = RW'(2 * N_BOUNCE);
              gap_next    = gap_load;
            end else begin
              state_next  = SETTLE;
              settle_next = SW'(SETTLE_CYC);
            end
          end
        end
      end
      BOUNCE: begin
        if (gap_cnt <= GW'(1)) begin
          // The last toggle of a pair always lands back on the target level.
          sw_next     = (remain == RW'(1)) ? tgt : ~o_sw;
          tog_next    = (o_toggles == 8'hFF) ? o_toggles : o_toggles + 8'd1;
          remain_next = remain - RW'(1);
          gap_next    = gap_load;
          if (remain == RW'(1)) begin
            state_next  = SETTLE;
            settle_next = SW'(SETTLE_CYC);
          end
        end else begin
          gap_next = gap_cnt - GW'(1);
        end
      end
      SETTLE: begin
        if (settle_cnt <= SW'(1)) begin
          state_next = DONE;
        end else begin
          settle_next = settle_cnt - SW'(1);
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    done_next = (state_next == DONE);
  end

endmodule

// File: tb/tb_switch_bounce_gen.sv
// tb/tb_switch_bounce_gen.sv - directed bench for switch_bounce_gen
module tb_switch_bounce_gen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       level = 1'b0;
  logic       req_b = 1'b0;
  logic       req_c = 1'b0;
  logic       b_busy, b_done, b_sw;
  logic [7:0] b_toggles;
  logic       c_busy, c_done, c_sw;
  logic [7:0] c_toggles;
  logic [15:0] m_lfsr, m_prev;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  switch_bounce_gen #(.N_BOUNCE(2), .GAP_W(2), .GAP_MIN(3), .SETTLE_CYC(10), .LFSR_SEED(16'hACE1)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req_b), .i_level(level),
    .o_busy(b_busy), .o_done(b_done), .o_sw(b_sw), .o_toggles(b_toggles)
  );

  switch_bounce_gen #(.N_BOUNCE(0), .SETTLE_CYC(10)) dut_c (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req_c), .i_level(level),
    .o_busy(c_busy), .o_done(c_done), .o_sw(c_sw), .o_toggles(c_toggles)
  );

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  // Reference LFSR; m_prev holds the value that was current during the previous cycle.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_lfsr <= 16'hACE1;
      m_prev <= 16'hACE1;
    end else begin
      m_prev <= m_lfsr;
      m_lfsr <= lfsr_step(m_lfsr);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue a press on dut_b and follow it to completion, checking every gap against the model.
  task automatic run_b(input logic lvl, input int exp_edges, input logic exp_sw,
                       input int poke_at, input bit poke_done, input bit abort);
    logic prev;
    int edges, since, exp_gap;
    bit fin;
    prev = b_sw;
    edges = 0; since = -1; exp_gap = 0; fin = 0;
    level = lvl;
    req_b = 1'b1;
    for (int t = 1; t <= 300 && !fin; t++) begin
      @(negedge clk);
      if (t == 1) begin
        req_b = 1'b0;
        chk("busy_after_accept", 32'(b_busy), 32'(1));
      end
      if (t == poke_at + 1) req_b = 1'b0;
      if (t == poke_at) begin
        req_b = 1'b1;
        level = ~lvl;
      end
      since++;
      if (b_sw !== prev) begin
        edges++;
        if (edges > 1) chk("gap", 32'(since), 32'(exp_gap));
        exp_gap = 3 + int'(m_prev[1:0]);
        since = 0;
        prev = b_sw;
      end
      if (abort && edges == 2 && since == 2) begin
        rst_n = 1'b0;
        #1;
        chk("abort_sw", 32'(b_sw), 32'(0));
        chk("abort_busy", 32'(b_busy), 32'(0));
        chk("abort_toggles", 32'(b_toggles), 32'(0));
        fin = 1;
      end else if (b_done) begin
        chk("settle_len", 32'(since), 32'(10));
        chk("edges", 32'(edges), 32'(exp_edges));
        chk("final_sw", 32'(b_sw), 32'(exp_sw));
        chk("toggles", 32'(b_toggles), 32'(exp_edges));
        if (poke_done) begin
          req_b = 1'b1;
          level = ~lvl;
        end
        @(negedge clk);
        req_b = 1'b0;
        chk("done_one_cycle", 32'(b_done), 32'(0));
        chk("busy_after_done", 32'(b_busy), 32'(1));
        @(negedge clk);
        chk("busy_dropped", 32'(b_busy), 32'(0));
        chk("no_second_done", 32'(b_done), 32'(0));
        chk("sw_hold", 32'(b_sw), 32'(exp_sw));
        fin = 1;
      end
    end
    if (!fin) chk("timeout", 32'(0), 32'(1));
  endtask

  initial begin
    // Reset held for 5 clocks.
    repeat (5) @(negedge clk);
    chk("rst_sw", 32'(b_sw), 32'(0));
    chk("rst_busy", 32'(b_busy), 32'(0));
    chk("rst_done", 32'(b_done), 32'(0));
    chk("rst_toggles", 32'(b_toggles), 32'(0));
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_b", {b_toggles, b_sw, b_busy, b_done}, 32'(0));
      chk("idle_c", {c_toggles, c_sw, c_busy, c_done}, 32'(0));
    end

    // Clean press on the bounce-free instance: edge at k+1, done at k+11, busy k+1..k+12.
    level = 1'b1;
    req_c = 1'b1;
    for (int i = 1; i <= 13; i++) begin
      @(negedge clk);
      req_c = 1'b0;
      chk("clean_sw", 32'(c_sw), 32'(1));
      chk("clean_done", 32'(c_done), 32'(i == 11));
      chk("clean_busy", 32'(c_busy), 32'(i <= 12));
    end
    chk("clean_toggles", 32'(c_toggles), 32'(1));
    chk("clean_b_idle", 32'(b_busy), 32'(0));

    // Bounced press to 1.
    run_b(1'b1, 5, 1'b1, -5, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    // Same-level press: no edge, done 10 clocks after acceptance.
    run_b(1'b1, 0, 1'b1, -5, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    // Release to 0 so the overlap case has a real transition.
    run_b(1'b0, 5, 1'b0, -5, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    // Requests during BOUNCE and in the DONE cycle are ignored.
    run_b(1'b1, 5, 1'b1, 4, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    chk("overlap_idle_busy", 32'(b_busy), 32'(0));
    chk("overlap_idle_sw", 32'(b_sw), 32'(1));

    // Reset two clocks after the second edge, then a fresh press completes.
    run_b(1'b0, 5, 1'b0, -5, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    chk("in_reset_sw", 32'(b_sw), 32'(0));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_reset_busy", 32'(b_busy), 32'(0));
    run_b(1'b1, 5, 1'b1, -5, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
